// File: rtl/hz_pkg.sv
// Shared types for the hazard controller: FSM encoding, stage tag layout and
// the architectural register constants the tag logic relies on.
package hz_pkg;

    localparam int TAG_REGW = 4;

    localparam logic [TAG_REGW-1:0] REG_ZERO = '0;
    localparam logic [TAG_REGW-1:0] REG_PC   = 4'd15;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_LDSTALL = 2'd1,
        HZ_MUL     = 2'd2,
        HZ_FLUSH   = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic [TAG_REGW-1:0] dst;
        logic                regwrite;
        logic                r15write;
        logic                isload;
        logic                ismul;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    // r0 is hardwired, so a write to it can never feed a consumer.
    function automatic stage_tag_t make_tag(
        input logic [TAG_REGW-1:0] dst,
        input logic                regwrite,
        input logic                r15write,
        input logic                isload,
        input logic                ismul
    );
        stage_tag_t t;
        t.dst      = dst;
        t.regwrite = regwrite && (dst != REG_ZERO);
        t.r15write = r15write;
        t.isload   = isload;
        t.ismul    = ismul;
        return t;
    endfunction

endpackage

// File: rtl/hz_tag_pipe.sv
// Three-stage destination tag shift register (X, M, W). X can be held while a
// multi-cycle operation occupies execute; M then receives a bubble.
module hz_tag_pipe
    import hz_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold_x,
    input  stage_tag_t d_tag,
    output stage_tag_t x_tag,
    output stage_tag_t m_tag,
    output stage_tag_t w_tag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_tag <= TAG_BUBBLE;
            m_tag <= TAG_BUBBLE;
            w_tag <= TAG_BUBBLE;
        end else begin
            if (!hold_x) begin
                x_tag <= d_tag;
            end
            m_tag <= hold_x ? TAG_BUBBLE : x_tag;
            w_tag <= m_tag;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks in-flight destination tags for the forwarding unit
// and raises stall/flush/bubble controls for load-use, multiply and branches.
module hazard_ctrl
    import hz_pkg::*;
#(
    parameter int REGW    = 4,
    parameter int MUL_LAT = 3,
    parameter int CNTW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_valid,
    input  logic [REGW-1:0] d_op1,
    input  logic [REGW-1:0] d_op2,
    input  logic            d_use2,
    input  logic [REGW-1:0] d_dst,
    input  logic            d_regwrite,
    input  logic            d_r15write,
    input  logic            d_isload,
    input  logic            d_ismul,
    input  logic            x_branch_taken,
    output logic [REGW-1:0] x_mop2,
    output logic [REGW-1:0] m_wop2,
    output logic            x_mregwrite,
    output logic            m_wregwrite,
    output logic            x_mr15write,
    output logic            m_wr15write,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_x,
    output logic            flush_d,
    output logic            bubble_x,
    output logic            bubble_m,
    output logic [1:0]      hz_state
);

    if (REGW != TAG_REGW) begin : g_regw_check
        $error("hazard_ctrl: REGW must equal hz_pkg::TAG_REGW");
    end

    localparam logic            MUL_STALLS   = (MUL_LAT > 1);
    localparam logic [CNTW-1:0] MUL_CNT_INIT = CNTW'(MUL_LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE      = CNTW'(1);

    hz_state_e       state;
    logic [CNTW-1:0] mul_cnt;
    logic            rst_q;

    stage_tag_t d_tag;
    stage_tag_t x_tag;
    stage_tag_t m_tag;
    stage_tag_t w_tag;

    logic active;
    logic mul_busy;
    logic branch_hit;
    logic lu_hit;
    logic kill_x;
    logic mul_start;

    // Controls stay quiet during reset and the cycle after it.
    assign active   = !rst && !rst_q;
    assign mul_busy = !rst && (mul_cnt != '0);

    assign branch_hit = active && !mul_busy && x_branch_taken;
    assign lu_hit     = active && !mul_busy && d_valid
                        && x_tag.isload && x_tag.regwrite
                        && ((x_tag.dst == d_op1) || (d_use2 && (x_tag.dst == d_op2)));
    assign kill_x     = branch_hit || lu_hit;

    always_comb begin
        d_tag = TAG_BUBBLE;
        if (d_valid && !kill_x) begin
            d_tag = make_tag(d_dst, d_regwrite, d_r15write, d_isload, d_ismul);
        end
    end

    assign mul_start = !rst && !mul_busy && MUL_STALLS && d_tag.ismul;

    hz_tag_pipe u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .hold_x (mul_busy),
        .d_tag  (d_tag),
        .x_tag  (x_tag),
        .m_tag  (m_tag),
        .w_tag  (w_tag)
    );

    // A taken branch redirects the PC, so it cancels any load-use hold.
    assign stall_f  = mul_busy || (lu_hit && !branch_hit);
    assign stall_d  = mul_busy || (lu_hit && !branch_hit);
    assign stall_x  = mul_busy;
    assign bubble_m = mul_busy;
    assign flush_d  = branch_hit;
    assign bubble_x = kill_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HZ_RUN;
            mul_cnt <= '0;
            rst_q   <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (mul_cnt != '0) begin
                mul_cnt <= mul_cnt - CNT_ONE;
            end else if (mul_start) begin
                mul_cnt <= MUL_CNT_INIT;
            end
            case (state)
                HZ_MUL: begin
                    if (mul_cnt <= CNT_ONE) begin
                        state <= HZ_RUN;
                    end
                end
                default: begin
                    if (branch_hit) begin
                        state <= HZ_FLUSH;
                    end else if (mul_start) begin
                        state <= HZ_MUL;
                    end else if (lu_hit) begin
                        state <= HZ_LDSTALL;
                    end else begin
                        state <= HZ_RUN;
                    end
                end
            endcase
        end
    end

    assign hz_state    = state;
    assign x_mop2      = m_tag.dst;
    assign x_mregwrite = m_tag.regwrite;
    assign x_mr15write = m_tag.r15write;
    assign m_wop2      = w_tag.dst;
    assign m_wregwrite = w_tag.regwrite;
    assign m_wr15write = w_tag.r15write;

    logic unused_tag_bits;
    assign unused_tag_bits = ^{x_tag.r15write, x_tag.ismul, m_tag.isload, m_tag.ismul,
                               w_tag.isload, w_tag.ismul, REG_PC};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, multiply, branch, r0, r15 and reset paths.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid;
    logic [3:0] d_op1;
    logic [3:0] d_op2;
    logic       d_use2;
    logic [3:0] d_dst;
    logic       d_regwrite;
    logic       d_r15write;
    logic       d_isload;
    logic       d_ismul;
    logic       x_branch_taken;
    logic [3:0] x_mop2;
    logic [3:0] m_wop2;
    logic       x_mregwrite;
    logic       m_wregwrite;
    logic       x_mr15write;
    logic       m_wr15write;
    logic       stall_f;
    logic       stall_d;
    logic       stall_x;
    logic       flush_d;
    logic       bubble_x;
    logic       bubble_m;
    logic [1:0] hz_state;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.REGW(4), .MUL_LAT(3), .CNTW(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .d_valid        (d_valid),
        .d_op1          (d_op1),
        .d_op2          (d_op2),
        .d_use2         (d_use2),
        .d_dst          (d_dst),
        .d_regwrite     (d_regwrite),
        .d_r15write     (d_r15write),
        .d_isload       (d_isload),
        .d_ismul        (d_ismul),
        .x_branch_taken (x_branch_taken),
        .x_mop2         (x_mop2),
        .m_wop2         (m_wop2),
        .x_mregwrite    (x_mregwrite),
        .m_wregwrite    (m_wregwrite),
        .x_mr15write    (x_mr15write),
        .m_wr15write    (m_wr15write),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_x        (stall_x),
        .flush_d        (flush_d),
        .bubble_x       (bubble_x),
        .bubble_m       (bubble_m),
        .hz_state       (hz_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [3:0] op1, input logic [3:0] op2,
                         input logic use2, input logic [3:0] dst, input logic rw,
                         input logic r15, input logic ld, input logic mul);
        d_valid    = v;
        d_op1      = op1;
        d_op2      = op2;
        d_use2     = use2;
        d_dst      = dst;
        d_regwrite = rw;
        d_r15write = r15;
        d_isload   = ld;
        d_ismul    = mul;
    endtask

    // Advance to the next falling edge with a NOP in decode and no branch.
    task automatic tick();
        @(negedge clk);
        rst            = 1'b0;
        x_branch_taken = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst            = 1'b1;
        x_branch_taken = 1'b1;
        set_d(1, 3, 3, 1, 3, 1, 0, 1, 0);

        // reset cycle: controls quiet even with a branch asserted
        @(negedge clk); #1;
        chk("rst_flush_d", flush_d, 0);
        chk("rst_stall_f", stall_f, 0);
        chk("rst_hz_state", hz_state, 0);
        chk("rst_x_mop2", x_mop2, 0);
        chk("rst_m_wregwrite", m_wregwrite, 0);

        // cycle after reset: still quiet
        tick(); x_branch_taken = 1'b1; #1;
        chk("post_rst_flush_d", flush_d, 0);
        chk("post_rst_bubble_x", bubble_x, 0);
        chk("post_rst_stall_x", stall_x, 0);

        // load-use on op1
        tick(); set_d(1, 0, 0, 0, 3, 1, 0, 1, 0);
        tick(); set_d(1, 3, 0, 0, 4, 1, 0, 0, 0); #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_bubble_x", bubble_x, 1);
        chk("lu_stall_x", stall_x, 0);
        chk("lu_flush_d", flush_d, 0);
        tick(); set_d(1, 3, 0, 0, 4, 1, 0, 0, 0); #1;
        chk("lu_after_stall_f", stall_f, 0);
        chk("lu_after_bubble_x", bubble_x, 0);
        chk("lu_after_x_mop2", x_mop2, 3);
        chk("lu_after_x_mregwrite", x_mregwrite, 1);
        chk("lu_after_hz_state", hz_state, 1);
        tick(); #1;
        chk("lu_w_m_wop2", m_wop2, 3);
        chk("lu_w_m_wregwrite", m_wregwrite, 1);
        chk("lu_w_x_mregwrite", x_mregwrite, 0);
        chk("lu_w_hz_state", hz_state, 0);

        // load-use on op2 only counts when op2 is read
        tick(); set_d(1, 0, 0, 0, 6, 1, 0, 1, 0);
        tick(); set_d(1, 1, 6, 0, 2, 1, 0, 0, 0); #1;
        chk("lu_op2_unused_stall_f", stall_f, 0);
        tick(); set_d(1, 0, 0, 0, 6, 1, 0, 1, 0);
        tick(); set_d(1, 1, 6, 1, 2, 1, 0, 0, 0); #1;
        chk("lu_op2_used_stall_d", stall_d, 1);
        chk("lu_op2_used_bubble_x", bubble_x, 1);
        tick();
        tick();

        // load to r0 is never a hazard source
        tick(); set_d(1, 0, 0, 0, 0, 1, 0, 1, 0);
        tick(); set_d(1, 0, 0, 0, 1, 0, 0, 0, 0); #1;
        chk("r0_stall_f", stall_f, 0);
        chk("r0_bubble_x", bubble_x, 0);
        tick(); #1;
        chk("r0_x_mregwrite", x_mregwrite, 0);

        // multiply: two stall cycles with MUL_LAT = 3, branch ignored meanwhile
        tick();
        tick(); set_d(1, 1, 2, 1, 5, 1, 0, 0, 1); #1;
        chk("mul_enter_stall_x", stall_x, 0);
        tick(); x_branch_taken = 1'b1; #1;
        chk("mul_c1_stall_x", stall_x, 1);
        chk("mul_c1_stall_f", stall_f, 1);
        chk("mul_c1_stall_d", stall_d, 1);
        chk("mul_c1_bubble_m", bubble_m, 1);
        chk("mul_c1_hz_state", hz_state, 2);
        chk("mul_c1_flush_d", flush_d, 0);
        tick(); #1;
        chk("mul_c2_stall_x", stall_x, 1);
        chk("mul_c2_hz_state", hz_state, 2);
        tick(); #1;
        chk("mul_done_stall_x", stall_x, 0);
        chk("mul_done_bubble_m", bubble_m, 0);
        chk("mul_done_hz_state", hz_state, 0);
        chk("mul_done_x_mregwrite", x_mregwrite, 0);
        tick(); #1;
        chk("mul_m_x_mop2", x_mop2, 5);
        chk("mul_m_x_mregwrite", x_mregwrite, 1);
        chk("mul_m_bubble_m", bubble_m, 0);

        // branch overrides a simultaneous load-use
        tick(); set_d(1, 0, 0, 0, 7, 1, 0, 1, 0);
        tick(); set_d(1, 7, 0, 0, 8, 1, 0, 0, 0); x_branch_taken = 1'b1; #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_stall_f", stall_f, 0);
        chk("br_stall_d", stall_d, 0);
        chk("br_bubble_x", bubble_x, 1);
        tick(); #1;
        chk("br_hz_state_flush", hz_state, 3);
        chk("br_flush_d_drop", flush_d, 0);
        tick(); #1;
        chk("br_hz_state_run", hz_state, 0);

        // r15 write tag travels X -> M -> W
        tick(); set_d(1, 0, 0, 0, 15, 1, 1, 0, 0);
        tick(); #1;
        chk("r15_x_mr15write_early", x_mr15write, 0);
        tick(); #1;
        chk("r15_x_mr15write", x_mr15write, 1);
        chk("r15_m_wr15write_early", m_wr15write, 0);
        tick(); #1;
        chk("r15_x_mr15write_drop", x_mr15write, 0);
        chk("r15_m_wr15write", m_wr15write, 1);
        tick(); #1;
        chk("r15_m_wr15write_drop", m_wr15write, 0);

        // reset while the multiply counter reads 1
        tick(); set_d(1, 0, 0, 0, 9, 1, 0, 0, 1);
        tick(); #1;
        chk("rmul_stall_x", stall_x, 1);
        tick(); rst = 1'b1; #1;
        chk("rmul_rst_stall_x", stall_x, 0);
        chk("rmul_rst_stall_f", stall_f, 0);
        chk("rmul_rst_bubble_m", bubble_m, 0);
        tick(); #1;
        chk("rmul_hz_state", hz_state, 0);
        chk("rmul_stall_x_after", stall_x, 0);
        chk("rmul_x_mop2", x_mop2, 0);
        chk("rmul_x_mregwrite", x_mregwrite, 0);
        chk("rmul_m_wop2", m_wop2, 0);
        tick(); #1;
        chk("rmul_stall_x_later", stall_x, 0);
        chk("rmul_hz_state_later", hz_state, 0);
        chk("rmul_x_mop2_later", x_mop2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer-side companion to the operand forwarding unit.
- Tracks in-flight destination tags through the X, M and W stages and drives the x_m*/m_w* tag signals that the forwarding unit consumes.
- Detects hazards that forwarding cannot cover (load-use, multi-cycle multiply, taken branch) and generates pipeline stall, bubble and flush controls.
- Sits beside the decode/execute boundary of the 5-stage datapath.

Parameters:
- REGW, 4, register index width.
- MUL_LAT, 3, execute cycles of a multiply (1 = no stall).
- CNTW, 2, multiply stall counter width; must hold MUL_LAT-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d_valid  in  1  decode holds a real instruction.
- d_op1  in  REGW  decode source register A.
- d_op2  in  REGW  decode source register B.
- d_use2  in  1  d_op2 is actually read.
- d_dst  in  REGW  decode destination register.
- d_regwrite  in  1  decode instruction writes d_dst.
- d_r15write  in  1  decode instruction writes r15 (link/PC).
- d_isload  in  1  decode instruction is a load.
- d_ismul  in  1  decode instruction is a multiply.
- x_branch_taken  in  1  branch resolved taken in X this cycle.
- x_mop2  out  REGW  destination tag at the X/M boundary.
- m_wop2  out  REGW  destination tag at the M/W boundary.
- x_mregwrite  out  1  X/M tag is a live register write.
- m_wregwrite  out  1  M/W tag is a live register write.
- x_mr15write  out  1  X/M writes r15.
- m_wr15write  out  1  M/W writes r15.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold F/D register.
- stall_x  out  1  hold D/X register (multiply busy).
- flush_d  out  1  kill the instruction in D.
- bubble_x  out  1  insert NOP into X next cycle.
- bubble_m  out  1  insert NOP into M next cycle.
- hz_state  out  2  FSM state, for debug.

Behaviour:
- Tag registers:
  - Three stage tag sets (X, M, W), each holding {dst, regwrite, r15write, isload, ismul}.
  - Outputs x_mop2/x_mregwrite/x_mr15write come from the M tag set; m_w* outputs come from the W tag set. All are registered.
- Reset:
  - All tag sets cleared to zero; FSM goes to RUN; counter = 0.
  - All stall/flush/bubble outputs read 0 in the reset cycle and the cycle after.
  - Reset mid-stall or mid-flush abandons the operation immediately.
- Register 0 is never a hazard source. A tag with dst = 0 is treated as regwrite = 0.
- Load-use hazard (LU):
  - Condition: X.isload and X.regwrite and d_valid, and either X.dst == d_op1 or (d_use2 and X.dst == d_op2).
  - Response: stall_f = stall_d = bubble_x = 1 for exactly one cycle, then the FSM returns to RUN.
- Multiply:
  - When a multiply enters X, counter loads MUL_LAT-1.
  - While counter != 0: stall_f = stall_d = stall_x = bubble_m = 1; counter decrements by 1 per cycle.
  - Counter never wraps below 0.
- Taken branch (x_branch_taken = 1, sampled only when stall_x = 0):
  - flush_d = bubble_x = 1 for one cycle.
  - Overrides LU in the same cycle: stall_f = stall_d = 0, since the PC must redirect.
- FSM states:
  - RUN: normal operation. Branch -> FLUSH; else multiply in X with MUL_LAT > 1 -> MUL; else LU -> LDSTALL; else stay in RUN.
  - LDSTALL: one cycle, then RUN.
  - MUL: leaves to RUN in the cycle the counter reaches 0. x_branch_taken is ignored while in MUL.
  - FLUSH: one cycle, then RUN.
- Priority order: rst > branch > MUL > LU.
- Tag advance:
  - Normal cycle: X <= D (zeroed if bubble_x or !d_valid); M <= X; W <= M.
  - stall_x: X holds its contents; M <= bubble; W <= M.
- Only the hazard outputs are combinational; they are a function of the registered state and the D inputs. There is no combinational path from the x_m*/m_w* outputs back into this block.

Decomposition:
- Shared package hz_pkg:
  - FSM state encoding: RUN = 0, LDSTALL = 1, MUL = 2, FLUSH = 3.
  - Stage tag struct.
  - REG_ZERO = 0 and REG_PC = 15 constants.
- One sub-module, hz_tag_pipe: the three-stage tag shift register with hold and bubble controls.

Test Plan:
- Load-use: ldr r3 (X.dst = 3, isload) with D add reading d_op1 = 3 -> one cycle of stall_f = stall_d = bubble_x = 1, then next cycle x_mop2 = 3, x_mregwrite = 1, stall_f = 0.
- Multiply with MUL_LAT = 3: mul r5 enters X -> stall_x = 1 for exactly 2 cycles, hz_state = 2, then x_mop2 = 5 while bubble_m = 0.
- Branch and LU together: x_branch_taken = 1 in the same cycle as an LU condition -> flush_d = 1, stall_f = 0, hz_state = 3 for one cycle, then 0.
- Register 0: load with X.dst = 0 and d_op1 = 0 -> no stall; x_mregwrite = 0 the following cycle.
- Reset mid-MUL: rst = 1 while counter = 1 -> next cycle hz_state = 0, all tags = 0, stall_x = 0.
- r15 path: d_r15write = 1 instruction advances -> x_mr15write = 1 one cycle later, m_wr15write = 1 two cycles later, then both return to 0.
